// File: rtl/seq_alu.sv
// Registered multi-cycle ALU with valid/ready handshakes on both sides.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier (op 101).
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags,
  output logic             busy
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL, OP_LSL, OP_LSR
  } op_t;

  state_t           state, state_nxt;
  op_t              op;
  logic             accept;
  logic             start_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] alu_r;
  logic [3:0]       alu_f;

  assign op        = op_t'(ALUControl);
  assign in_ready  = ~reset & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == HOLD);

  // Single-cycle datapath, evaluated on the live operands at the accept edge.
  always_comb begin
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   cin;
    logic [SHW-1:0]   sh;
    logic             c;
    logic             v;
    bb    = (op == OP_SUB) ? ~b : b;
    cin   = {{WIDTH{1'b0}}, (op == OP_SUB)};
    sh    = b[SHW-1:0];
    c     = 1'b0;
    v     = 1'b0;
    alu_r = '0;
    case (op)
      OP_ADD, OP_SUB: begin
        {c, alu_r} = {1'b0, a} + {1'b0, bb} + cin;
        v = (a[WIDTH-1] == bb[WIDTH-1]) && (alu_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_r = a & b;
      OP_OR:   alu_r = a | b;
      OP_XOR:  alu_r = a ^ b;
      // Widened shifts: the extra bit catches the last bit shifted out (0 for sh==0).
      OP_LSL:  {c, alu_r} = {1'b0, a} << sh;
      OP_LSR:  {alu_r, c} = {a, 1'b0} >> sh;
      default: alu_r = '0;
    endcase
    alu_f = {alu_r[WIDTH-1], (alu_r == '0), c, v};
  end

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [SHW:0]     cnt;

  assign start_mul = accept & (op == OP_MUL);
  // The counter is still 1 on the final iteration edge; it reaches 0 as HOLD loads.
  assign mul_done  = (state == MUL) & (cnt == 1);
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign mul_res   = acc_nxt;
  assign busy      = (state == MUL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start_mul) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= WIDTH[SHW:0];
    end else if (state == MUL) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
      cnt    <= cnt - 1'b1;
    end
  end
`else
  assign start_mul = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign busy      = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HOLD: begin
        if (accept)                          state_nxt = start_mul ? MUL : HOLD;
        else if (state == HOLD && out_ready) state_nxt = IDLE;
      end
      MUL:     if (mul_done) state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Result   <= '0;
      ALUFlags <= 4'b0000;
    end else if (accept && !start_mul) begin
      Result   <= alu_r;
      ALUFlags <= alu_f;
    end else if (mul_done) begin
      Result   <= mul_res;
      ALUFlags <= {mul_res[WIDTH-1], (mul_res == '0), 2'b00};
    end
  end

endmodule
